// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory port.
package mips_bus_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h0;
    localparam int unsigned CNT_W        = 4;

    typedef logic [3:0] byte_en_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        byte_en_t    byteenable;
    } bus_req_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } bus_state_t;

endpackage

// File: rtl/mips_bus_mem_array.sv
// Single-port byte-writable RAM with synchronous read; storage only.
// Ports: clk; i_we/i_be/i_wdata write lanes at i_addr; i_re loads o_rdata
// from i_addr on the same edge. Contents are never reset.
module mips_bus_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    input  logic [3:0]                     i_be,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Per-lane write and registered read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_bus_memory.sv
// Word-addressed memory slave for the mips_cpu_bus port with programmable
// wait states, byte-enabled writes and a sticky protocol-violation flag.
// Ports: clk, reset (async, high); address/read/write/writedata/byteenable
// request from the CPU; waitrequest (combinational stall), readdata
// (registered), protocol_error (sticky until reset).
module mips_bus_memory
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  byte_en_t    byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_error
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    bus_state_t       r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    bus_req_t         w_cur, r_prev;
    logic             r_prev_wait;
    logic             r_sel_mem;
    logic             w_req, w_done, w_abort, w_err_set;
    logic [31:0]      w_off, w_mem_rdata;
    logic [AW-1:0]    w_idx;
    logic             w_in_range, w_do_write, w_do_read, w_rd_mem;

    assign w_req       = read | write;
    assign waitrequest = w_req && (r_cnt != CNT_W'(WAIT_STATES));
    assign w_done      = w_req && !waitrequest;

    // Address decode; offsets below BASE_ADDR wrap to large values and fail the range test.
    assign w_off      = address - BASE_ADDR;
    assign w_in_range = w_off < SPAN;
    assign w_idx      = w_off[AW+1:2];

    // Simultaneous read+write is serviced as a write.
    assign w_do_write = w_done && write && w_in_range;
    assign w_do_read  = w_done && !write;
    assign w_rd_mem   = w_do_read && w_in_range && (address != HALT_ADDR);

    // Wait-state sequencing.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && waitrequest) begin
                    w_cnt_n   = r_cnt + CNT_W'(1);
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                    w_abort   = 1'b1;
                end else if (waitrequest) begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end else begin
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_cnt_n   = '0;
                w_state_n = S_IDLE;
            end
        endcase
    end

    // A stalled master must present identical request inputs on the following cycle.
    assign w_cur     = '{address: address, read: read, write: write,
                         writedata: writedata, byteenable: byteenable};
    assign w_err_set = w_abort | (read & write) | (r_prev_wait && (w_cur != r_prev));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_prev         <= '0;
            r_prev_wait    <= 1'b0;
            r_sel_mem      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_cnt          <= w_cnt_n;
            r_prev         <= w_cur;
            r_prev_wait    <= waitrequest;
            protocol_error <= protocol_error | w_err_set;
            if (w_do_read) r_sel_mem <= w_rd_mem;
        end
    end

    mips_bus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_do_write),
        .i_re    (w_rd_mem),
        .i_addr  (w_idx),
        .i_wdata (writedata),
        .i_be    (byteenable),
        .o_rdata (w_mem_rdata)
    );

    // The array register only reloads on in-range reads; halt/out-of-range reads force zero.
    assign readdata = r_sel_mem ? w_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench: four instances with WAIT_STATES = 0, 2, 3, 4.
module tb_mips_bus_memory;

    logic        clk;
    logic        b_rst   [4];
    logic [31:0] b_addr  [4];
    logic        b_rd    [4];
    logic        b_wr    [4];
    logic [31:0] b_wdata [4];
    logic [3:0]  b_be    [4];
    logic        wreq    [4];
    logic [31:0] rdata   [4];
    logic        perr    [4];

    int n_chk  = 0;
    int n_pass = 0;
    int st;
    int tot;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
        mips_bus_memory #(.WAIT_STATES(WS)) u_dut (
            .clk            (clk),
            .reset          (b_rst[g]),
            .address        (b_addr[g]),
            .read           (b_rd[g]),
            .write          (b_wr[g]),
            .writedata      (b_wdata[g]),
            .byteenable     (b_be[g]),
            .waitrequest    (wreq[g]),
            .readdata       (rdata[g]),
            .protocol_error (perr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One transfer starting at a negedge; returns the number of stalled cycles.
    task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output int stalls);
        b_addr[d] = a; b_rd[d] = rd; b_wr[d] = wr; b_wdata[d] = wd; b_be[d] = be;
        stalls = 0;
        #1;
        while (wreq[d] && stalls < 40) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 40) check("timeout", 32'(stalls), 32'd0);
        @(negedge clk);
        b_rd[d] = 1'b0; b_wr[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            b_rst[i] = 1'b1; b_addr[i] = '0; b_rd[i] = 1'b0; b_wr[i] = 1'b0;
            b_wdata[i] = '0; b_be[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) b_rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_perr", 32'(perr[i]), 32'h0);
            check("rst_wreq", 32'(wreq[i]), 32'h0);
        end
        @(negedge clk);

        // WS=0: load word 0 and read it back with no stall.
        xfer(0, 1'b0, 1'b1, 32'hBFC00000, 32'h3C021000, 4'hF, st);
        check("ws0_wr_stall", 32'(st), 32'd0);
        xfer(0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, st);
        check("ws0_rd_stall", 32'(st), 32'd0);
        check("ws0_rd_data", rdata[0], 32'h3C021000);

        // WS=3: partial write over a zeroed word, halt and out-of-range reads.
        xfer(2, 1'b0, 1'b1, 32'hBFC00010, 32'h0, 4'hF, st);
        check("ws3_zero_stall", 32'(st), 32'd3);
        xfer(2, 1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'b0101, st);
        check("ws3_wr_stall", 32'(st), 32'd3);
        xfer(2, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, st);
        check("ws3_rd_stall", 32'(st), 32'd3);
        check("ws3_be_data", rdata[2], 32'h00AD00EF);
        xfer(2, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'hF, st);
        check("halt_rd", rdata[2], 32'h0);
        xfer(2, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'hF, st);
        xfer(2, 1'b1, 1'b0, 32'h00001000, 32'h0, 4'hF, st);
        check("oor_rd", rdata[2], 32'h0);
        xfer(2, 1'b0, 1'b1, 32'hBFC00000, 32'h11111111, 4'hF, st);
        xfer(2, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'hF, st);
        xfer(2, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, st);
        check("oor_wr_dropped", rdata[2], 32'h11111111);
        check("ws3_perr", 32'(perr[2]), 32'h0);

        // WS=2: address change during stall, then reset and abort-by-reset.
        xfer(1, 1'b0, 1'b1, 32'hBFC00004, 32'hCAFEF00D, 4'hF, st);
        check("ws2_wr_stall", 32'(st), 32'd2);
        b_rd[1] = 1'b1; b_addr[1] = 32'hBFC00004;
        @(negedge clk);
        b_addr[1] = 32'hBFC00008;
        repeat (2) @(negedge clk);
        b_rd[1] = 1'b0;
        #1;
        check("addr_chg_perr", 32'(perr[1]), 32'h1);
        repeat (3) @(negedge clk);
        check("perr_sticky", 32'(perr[1]), 32'h1);
        b_rst[1] = 1'b1;
        #1;
        check("perr_clr", 32'(perr[1]), 32'h0);
        @(negedge clk);
        b_rst[1] = 1'b0;
        @(negedge clk);
        xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, st);
        check("mem_kept", rdata[1], 32'hCAFEF00D);
        b_wr[1] = 1'b1; b_addr[1] = 32'hBFC00004; b_wdata[1] = 32'h12345678; b_be[1] = 4'hF;
        @(negedge clk);
        b_rst[1] = 1'b1;
        #1;
        b_wr[1] = 1'b0;
        @(negedge clk);
        b_rst[1] = 1'b0;
        #1;
        check("abort_rdata", rdata[1], 32'h0);
        @(negedge clk);
        xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, st);
        check("abort_no_wr", rdata[1], 32'hCAFEF00D);

        // WS=4: dropped read, then simultaneous read+write.
        xfer(3, 1'b0, 1'b1, 32'hBFC00020, 32'hA5A5A5A5, 4'hF, st);
        check("ws4_wr_stall", 32'(st), 32'd4);
        xfer(3, 1'b0, 1'b1, 32'hBFC00024, 32'h5A5A0000, 4'hF, st);
        xfer(3, 1'b1, 1'b0, 32'hBFC00020, 32'h0, 4'hF, st);
        check("ws4_rd", rdata[3], 32'hA5A5A5A5);
        b_rd[3] = 1'b1; b_addr[3] = 32'hBFC00024;
        repeat (2) @(negedge clk);
        b_rd[3] = 1'b0;
        @(negedge clk);
        #1;
        check("drop_rdata", rdata[3], 32'hA5A5A5A5);
        check("drop_perr", 32'(perr[3]), 32'h1);
        @(negedge clk);
        b_rst[3] = 1'b1;
        @(negedge clk);
        b_rst[3] = 1'b0;
        @(negedge clk);
        xfer(3, 1'b1, 1'b0, 32'hBFC00024, 32'h0, 4'hF, st);
        check("drop_cnt_restart", 32'(st), 32'd4);
        check("drop_mem", rdata[3], 32'h5A5A0000);
        xfer(3, 1'b1, 1'b1, 32'hBFC00028, 32'h77777777, 4'hF, st);
        check("rdwr_rdata", rdata[3], 32'h5A5A0000);
        check("rdwr_perr", 32'(perr[3]), 32'h1);
        xfer(3, 1'b1, 1'b0, 32'hBFC00028, 32'h0, 4'hF, st);
        check("rdwr_wrote", rdata[3], 32'h77777777);

        // WS=0: back-to-back writes then reads over 8 words.
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 1'b1, 32'hBFC00040 + 32'(4 * i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF, st);
            tot += st;
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 1'b0, 32'hBFC00040 + 32'(4 * i), 32'h0, 4'hF, st);
            tot += st;
            check("b2b_rd", rdata[0], 32'h10000000 + 32'(i) * 32'h01010101);
        end
        check("b2b_stalls", 32'(tot), 32'd0);
        check("ws0_perr", 32'(perr[0]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
